// File: rtl/hamming13_rx_decoder_pkg.sv
// rtl/hamming13_rx_decoder_pkg.sv - Hamming (13,8) SECDED bit positions, status codes and data extraction
package hamming13_rx_decoder_pkg;

   localparam int CW_W = 13;
   localparam int DW_W = 8;

   // Bit index = Hamming position - 1; PT is the overall even parity bit
   localparam int P1_IDX = 0;
   localparam int P2_IDX = 1;
   localparam int D1_IDX = 2;
   localparam int P4_IDX = 3;
   localparam int D2_IDX = 4;
   localparam int D3_IDX = 5;
   localparam int D4_IDX = 6;
   localparam int P8_IDX = 7;
   localparam int D5_IDX = 8;
   localparam int D6_IDX = 9;
   localparam int D7_IDX = 10;
   localparam int D8_IDX = 11;
   localparam int PT_IDX = 12;

   typedef enum logic [1:0] {
      ST_CLEAN  = 2'b00,
      ST_CORR   = 2'b01,
      ST_PCORR  = 2'b10,
      ST_UNCORR = 2'b11
   } status_t;

   function automatic logic [DW_W-1:0] extract_data(input logic [CW_W-1:0] code);
      return {code[D8_IDX], code[D7_IDX], code[D6_IDX], code[D5_IDX],
              code[D4_IDX], code[D3_IDX], code[D2_IDX], code[D1_IDX]};
   endfunction

endpackage

// File: rtl/hamming13_rx_decoder_if.sv
// rtl/hamming13_rx_decoder_if.sv - codeword-in / byte-out handshake bundle of the RX decoder
interface hamming13_rx_decoder_if;
   import hamming13_rx_decoder_pkg::*;

   logic            in_valid;
   logic            in_ready;
   logic [CW_W-1:0] code_in;
   logic            out_valid;
   logic            out_ready;
   logic [DW_W-1:0] data_out;
   logic [1:0]      status_out;

   modport master (
      output in_valid, code_in, out_ready,
      input  in_ready, out_valid, data_out, status_out
   );

   modport slave (
      input  in_valid, code_in, out_ready,
      output in_ready, out_valid, data_out, status_out
   );

endinterface

// File: rtl/hamming13_syndrome.sv
// rtl/hamming13_syndrome.sv - combinational syndrome s[3:0] and overall parity q of a 13-bit codeword
module hamming13_syndrome
   import hamming13_rx_decoder_pkg::*;
(
   input  logic [CW_W-1:0] code,
   output logic [3:0]      syn,
   output logic            q
);

   // Each syndrome bit covers the positions whose index has that bit set
   assign syn[0] = code[P1_IDX] ^ code[D1_IDX] ^ code[D2_IDX] ^ code[D4_IDX]
                 ^ code[D5_IDX] ^ code[D7_IDX];
   assign syn[1] = code[P2_IDX] ^ code[D1_IDX] ^ code[D3_IDX] ^ code[D4_IDX]
                 ^ code[D6_IDX] ^ code[D7_IDX];
   assign syn[2] = code[P4_IDX] ^ code[D2_IDX] ^ code[D3_IDX] ^ code[D4_IDX]
                 ^ code[D8_IDX];
   assign syn[3] = code[P8_IDX] ^ code[D5_IDX] ^ code[D6_IDX] ^ code[D7_IDX]
                 ^ code[D8_IDX];

   assign q = (^code[PT_IDX-1:0]) ^ code[PT_IDX];

endmodule

// File: rtl/hamming13_rx_decoder.sv
// rtl/hamming13_rx_decoder.sv - two-stage SECDED decoder with stall, error status and saturating counters
module hamming13_rx_decoder
   import hamming13_rx_decoder_pkg::*;
#(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   hamming13_rx_decoder_if.slave bus,
   input  logic             clr_cnt,
   output logic [CNT_W-1:0] cnt_corr,
   output logic [CNT_W-1:0] cnt_uncorr,
   output logic             err_sticky
);

   logic            en;
   logic [3:0]      syn_c;
   logic            q_c;

   logic            s1_valid;
   logic [CW_W-1:0] s1_code;
   logic [3:0]      s1_syn;
   logic            s1_q;

   logic [CW_W-1:0] flip_mask;
   logic [CW_W-1:0] fixed_code;
   status_t         status_c;

   logic            s2_valid;
   logic [DW_W-1:0] s2_data;
   status_t         s2_status;

   logic            load_word;
   logic            inc_corr;
   logic            inc_uncorr;

   // One enable stalls the whole pipe; bubbles travel like words
   assign en           = !s2_valid || bus.out_ready;
   assign bus.in_ready = en;

   hamming13_syndrome u_syndrome (
      .code (bus.code_in),
      .syn  (syn_c),
      .q    (q_c)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid <= 1'b0;
         s1_code  <= '0;
         s1_syn   <= '0;
         s1_q     <= 1'b0;
      end else if (en) begin
         s1_valid <= bus.in_valid;
         if (bus.in_valid) begin
            s1_code <= bus.code_in;
            s1_syn  <= syn_c;
            s1_q    <= q_c;
         end
      end
   end

   assign flip_mask = CW_W'(1) << (s1_syn - 4'd1);

   always_comb begin
      status_c   = ST_CLEAN;
      fixed_code = s1_code;
      if (s1_syn == 4'd0) begin
         status_c = s1_q ? ST_PCORR : ST_CLEAN;
      end else if (!s1_q || s1_syn > 4'd12) begin
         status_c = ST_UNCORR;
      end else begin
         status_c   = ST_CORR;
         fixed_code = s1_code ^ flip_mask;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s2_valid  <= 1'b0;
         s2_data   <= '0;
         s2_status <= ST_CLEAN;
      end else if (en) begin
         s2_valid <= s1_valid;
         if (s1_valid) begin
            s2_data   <= extract_data(fixed_code);
            s2_status <= status_c;
         end
      end
   end

   assign bus.out_valid  = s2_valid;
   assign bus.data_out   = s2_data;
   assign bus.status_out = s2_status;

   assign load_word  = en && s1_valid;
   assign inc_corr   = load_word && (status_c == ST_CORR || status_c == ST_PCORR);
   assign inc_uncorr = load_word && (status_c == ST_UNCORR);

   // A clear in the same cycle as a counted word drops that word's count
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_corr   <= '0;
         cnt_uncorr <= '0;
         err_sticky <= 1'b0;
      end else if (clr_cnt) begin
         cnt_corr   <= '0;
         cnt_uncorr <= '0;
         err_sticky <= 1'b0;
      end else begin
         if (inc_corr && cnt_corr != {CNT_W{1'b1}}) begin
            cnt_corr <= cnt_corr + 1'b1;
         end
         if (inc_uncorr && cnt_uncorr != {CNT_W{1'b1}}) begin
            cnt_uncorr <= cnt_uncorr + 1'b1;
         end
         if (inc_uncorr) begin
            err_sticky <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_hamming13_rx_decoder.sv
// tb/tb_hamming13_rx_decoder.sv - directed-vector bench for hamming13_rx_decoder
module tb_hamming13_rx_decoder;

   localparam int CNT_W = 4;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             clr_cnt = 1'b0;
   logic [CNT_W-1:0] cnt_corr;
   logic [CNT_W-1:0] cnt_uncorr;
   logic             err_sticky;

   int n_checks = 0;
   int n_errors = 0;

   hamming13_rx_decoder_if bus ();

   hamming13_rx_decoder #(.CNT_W(CNT_W)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .bus        (bus.slave),
      .clr_cnt    (clr_cnt),
      .cnt_corr   (cnt_corr),
      .cnt_uncorr (cnt_uncorr),
      .err_sticky (err_sticky)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Single word through an idle pipe; output must appear two edges after acceptance
   task automatic send_word(input string tag, input logic [12:0] code,
                            input logic [7:0] exp_d, input logic [1:0] exp_s);
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.code_in  = code;
      #1;
      check_eq({tag, "_in_ready"}, 32'(bus.in_ready), 32'd1);
      @(negedge clk);
      bus.in_valid = 1'b0;
      check_eq({tag, "_early_valid"}, 32'(bus.out_valid), 32'd0);
      @(negedge clk);
      check_eq({tag, "_valid"}, 32'(bus.out_valid), 32'd1);
      check_eq({tag, "_data"}, 32'(bus.data_out), 32'(exp_d));
      check_eq({tag, "_status"}, 32'(bus.status_out), 32'(exp_s));
   endtask

   logic [12:0] bp_words [3];
   logic [9:0]  got_q [$];
   logic [9:0]  hold_v;
   int          idx;
   int          stray;

   initial begin
      bus.in_valid  = 1'b0;
      bus.code_in   = '0;
      bus.out_ready = 1'b1;
      bp_words[0] = 13'h0000;
      bp_words[1] = 13'h0A27;
      bp_words[2] = 13'h1A27;

      repeat (2) @(negedge clk);
      check_eq("rst_out_valid", 32'(bus.out_valid), 32'd0);
      check_eq("rst_data", 32'(bus.data_out), 32'd0);
      check_eq("rst_status", 32'(bus.status_out), 32'd0);
      check_eq("rst_cnt_corr", 32'(cnt_corr), 32'd0);
      check_eq("rst_cnt_uncorr", 32'(cnt_uncorr), 32'd0);
      check_eq("rst_sticky", 32'(err_sticky), 32'd0);
      rst_n = 1'b1;

      send_word("clean", 13'h0A27, 8'hA5, 2'b00);
      check_eq("clean_cnt_corr", 32'(cnt_corr), 32'd0);
      check_eq("clean_cnt_uncorr", 32'(cnt_uncorr), 32'd0);
      send_word("d4_flip", 13'h0A67, 8'hA5, 2'b01);
      check_eq("d4_cnt_corr", 32'(cnt_corr), 32'd1);
      send_word("pt_flip", 13'h1A27, 8'hA5, 2'b10);
      check_eq("pt_cnt_corr", 32'(cnt_corr), 32'd2);
      send_word("p1_flip", 13'h0A26, 8'hA5, 2'b01);
      send_word("d8_flip", 13'h0227, 8'hA5, 2'b01);
      check_eq("d8_cnt_corr", 32'(cnt_corr), 32'd4);
      send_word("double", 13'h0A36, 8'hA7, 2'b11);
      check_eq("double_cnt_uncorr", 32'(cnt_uncorr), 32'd1);
      check_eq("double_sticky", 32'(err_sticky), 32'd1);
      check_eq("double_cnt_corr", 32'(cnt_corr), 32'd4);
      send_word("syn13", 13'h0AAE, 8'hA5, 2'b11);
      check_eq("syn13_cnt_uncorr", 32'(cnt_uncorr), 32'd2);

      // clr_cnt coincides with the edge that loads a status-11 word into stage 2
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.code_in  = 13'h0A36;
      @(negedge clk);
      bus.in_valid = 1'b0;
      clr_cnt      = 1'b1;
      @(negedge clk);
      clr_cnt = 1'b0;
      check_eq("clr_status", 32'(bus.status_out), 32'd3);
      check_eq("clr_cnt_corr", 32'(cnt_corr), 32'd0);
      check_eq("clr_cnt_uncorr", 32'(cnt_uncorr), 32'd0);
      check_eq("clr_sticky", 32'(err_sticky), 32'd0);
      repeat (2) @(negedge clk);

      idx    = 0;
      hold_v = '0;
      for (int k = 0; k < 12; k++) begin
         @(negedge clk);
         bus.out_ready = !(k >= 2 && k <= 4);
         bus.in_valid  = (idx < 3);
         if (idx < 3) bus.code_in = bp_words[idx];
         #1;
         if (k >= 2 && k <= 4) begin
            check_eq("bp_in_ready", 32'(bus.in_ready), 32'd0);
            check_eq("bp_out_valid", 32'(bus.out_valid), 32'd1);
            if (k == 2) hold_v = {bus.data_out, bus.status_out};
            else check_eq("bp_hold", 32'({bus.data_out, bus.status_out}), 32'(hold_v));
         end
         if (bus.out_valid && bus.out_ready) got_q.push_back({bus.data_out, bus.status_out});
         if (bus.in_valid && bus.in_ready) idx++;
      end
      bus.in_valid = 1'b0;
      check_eq("bp_accepted", 32'(idx), 32'd3);
      check_eq("bp_count", 32'(got_q.size()), 32'd3);
      if (got_q.size() == 3) begin
         check_eq("bp_word0", 32'(got_q[0]), 32'({8'h00, 2'b00}));
         check_eq("bp_word1", 32'(got_q[1]), 32'({8'hA5, 2'b00}));
         check_eq("bp_word2", 32'(got_q[2]), 32'({8'hA5, 2'b10}));
      end

      // Reset with one word in each stage
      @(negedge clk);
      bus.out_ready = 1'b0;
      bus.in_valid  = 1'b1;
      bus.code_in   = 13'h0A67;
      @(negedge clk);
      bus.code_in   = 13'h0A26;
      @(negedge clk);
      bus.in_valid  = 1'b0;
      check_eq("flight_valid", 32'(bus.out_valid), 32'd1);
      #1 rst_n = 1'b0;
      #1;
      check_eq("arst_out_valid", 32'(bus.out_valid), 32'd0);
      check_eq("arst_data", 32'(bus.data_out), 32'd0);
      check_eq("arst_cnt_corr", 32'(cnt_corr), 32'd0);
      @(negedge clk);
      rst_n         = 1'b1;
      bus.out_ready = 1'b1;
      stray = 0;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         if (bus.out_valid) stray++;
      end
      check_eq("arst_no_output", 32'(stray), 32'd0);

      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         bus.in_valid = 1'b1;
         bus.code_in  = 13'h0A67;
      end
      @(negedge clk);
      bus.in_valid = 1'b0;
      repeat (3) @(negedge clk);
      check_eq("sat_cnt_corr", 32'(cnt_corr), 32'd15);
      check_eq("sat_cnt_uncorr", 32'(cnt_uncorr), 32'd0);
      check_eq("sat_drained", 32'(bus.out_valid), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
